// File: rtl/alu_pkg.sv
// Shared ALU definitions: data/immediate widths, opcodes, response FSM states
// and the combinational ALU function used by alu_arbiter.
package alu_pkg;

   localparam int DATA_W = 16;
   localparam int IMM_W  = 4;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_AND = 3'b010,
      OP_OR  = 3'b011,
      OP_SHL = 3'b100,
      OP_SHR = 3'b101,
      OP_SRA = 3'b110,
      OP_ROL = 3'b111
   } alu_op_e;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } rsp_state_e;

   function automatic logic [DATA_W-1:0] alu_compute(
      input alu_op_e           op,
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [IMM_W-1:0]  imm
   );
      logic [DATA_W-1:0]   result;
      logic [2*DATA_W-1:0] rot;
      // NOTE: every variable gets a default before the case, so no path leaves it unassigned and no latch is inferred.
      result = '0;
      // Rotating the doubled word makes imm=0 fall out naturally as A.
      rot    = {a, a} << imm;
      case (op)
         OP_ADD: result = a + b;
         OP_SUB: result = a - b;
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_SHL: result = a << imm;
         OP_SHR: result = a >> imm;
         OP_SRA: result = $unsigned($signed(a) >>> imm);
         OP_ROL: result = rot[2*DATA_W-1:DATA_W];
         default: result = '0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant. The pointer remembers the last requester
// that actually transferred and only moves when advance is asserted.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_q, last_d;

   always_comb begin
      grant  = valid;
      last_d = last_q;
      if (valid == 2'b11) begin
         grant = last_q ? 2'b01 : 2'b10;
      end
      if (advance) begin
         last_d = grant[1];
      end
   end

   // Reset to "requester 1 went last" so requester 0 wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignment so every register samples pre-edge values.
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin grant and a one-entry
// result register. Define ALU_ARBITER_FLAGS_EN to add rsp_zero/rsp_neg outputs.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [2:0]        req0_op,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [IMM_W-1:0]  req0_imm,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [2:0]        req1_op,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [IMM_W-1:0]  req1_imm,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_id,
   output logic [CNT_W-1:0]  op_count
`ifdef ALU_ARBITER_FLAGS_EN
   ,
   output logic              rsp_zero,
   output logic              rsp_neg
`endif
);

   rsp_state_e        state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              id_q, id_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [1:0]        grant;
   logic [1:0]        ready;
   logic              can_accept;
   logic              xfer;
   logic [DATA_W-1:0] result;

   rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .valid  ({req1_valid, req0_valid}),
      .advance(xfer),
      .grant  (grant)
   );

   // Ready looks only at grant and output-register space, never at the
   // payload; it is also forced low while reset is held.
   always_comb begin
      can_accept = (state_q == ST_EMPTY) || rsp_ready;
      ready      = rst_n ? (grant & {2{can_accept}}) : 2'b00;
      xfer       = |ready;
      result     = ready[1] ? alu_compute(alu_op_e'(req1_op), req1_a, req1_b, req1_imm)
                            : alu_compute(alu_op_e'(req0_op), req0_a, req0_b, req0_imm);
   end

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      id_d    = id_q;
      count_d = count_q;
      if (state_q == ST_FULL && rsp_ready) begin
         count_d = count_q + CNT_W'(1);
      end
      case (state_q)
         ST_EMPTY: if (xfer) state_d = ST_FULL;
         ST_FULL:  if (rsp_ready && !xfer) state_d = ST_EMPTY;
         default:  state_d = ST_EMPTY;
      endcase
      if (xfer) begin
         data_d = result;
         id_d   = ready[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
         id_q    <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         id_q    <= id_d;
         count_q <= count_d;
      end
   end

   assign rsp_valid = (state_q == ST_FULL);
   assign rsp_data  = data_q;
   assign rsp_id    = id_q;
   assign op_count  = count_q;

`ifdef ALU_ARBITER_FLAGS_EN
   logic zero_q, neg_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else if (xfer) begin
         zero_q <= (result == '0);
         neg_q  <= result[DATA_W-1];
      end
   end

   assign rsp_zero = zero_q;
   assign rsp_neg  = neg_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table plus directed sequences for
// round robin, backpressure and asynchronous reset; results checked via scoreboard.
module tb_alu_arbiter;

   localparam int CNT_W = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [2:0]  req0_op, req1_op;
   logic [15:0] req0_a, req0_b, req1_a, req1_b;
   logic [3:0]  req0_imm, req1_imm;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_data;
   logic        rsp_id;
   logic [CNT_W-1:0] op_count;
`ifdef ALU_ARBITER_FLAGS_EN
   logic        rsp_zero, rsp_neg;
`endif

   alu_arbiter #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req0_valid(req0_valid),
      .req0_ready(req0_ready),
      .req0_op   (req0_op),
      .req0_a    (req0_a),
      .req0_b    (req0_b),
      .req0_imm  (req0_imm),
      .req1_valid(req1_valid),
      .req1_ready(req1_ready),
      .req1_op   (req1_op),
      .req1_a    (req1_a),
      .req1_b    (req1_b),
      .req1_imm  (req1_imm),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
`ifdef ALU_ARBITER_FLAGS_EN
      ,
      .rsp_zero  (rsp_zero),
      .rsp_neg   (rsp_neg)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        req;
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  imm;
      logic [15:0] exp;
   } vec_t;

   typedef struct packed {
      logic [15:0] data;
      logic        id;
   } exp_t;

   vec_t vecs[15];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [CNT_W-1:0] exp_count = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input int r, input logic v, input logic [2:0] op,
                        input logic [15:0] a, input logic [15:0] b, input logic [3:0] imm);
      if (r == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b; req0_imm = imm;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b; req1_imm = imm;
      end
   endtask

   task automatic idle();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
      check(name, sb.size(), 0);
   endtask

   // Consumer-side monitor: every handshake on the response pops one expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && rsp_valid && rsp_ready) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data %h id %0d expected no response", rsp_data, rsp_id);
         end else begin
            e = sb.pop_front();
            check("rsp_data", rsp_data, e.data);
            check("rsp_id", rsp_id, e.id);
            check("op_count", op_count, exp_count);
`ifdef ALU_ARBITER_FLAGS_EN
            check("rsp_zero", rsp_zero, e.data == 16'h0000);
            check("rsp_neg", rsp_neg, e.data[15]);
`endif
         end
         exp_count = exp_count + 1'b1;
      end
   end

   initial begin
      vecs[0]  = '{1'b0, 3'b000, 16'h7FFF, 16'h0001, 4'd0,  16'h8000};
      vecs[1]  = '{1'b1, 3'b001, 16'h0005, 16'h0007, 4'd0,  16'hFFFE};
      vecs[2]  = '{1'b0, 3'b010, 16'hF0F0, 16'h3C3C, 4'd0,  16'h3030};
      vecs[3]  = '{1'b1, 3'b011, 16'hF0F0, 16'h0F01, 4'd0,  16'hFFF1};
      vecs[4]  = '{1'b0, 3'b100, 16'h8001, 16'h0000, 4'd4,  16'h0010};
      vecs[5]  = '{1'b1, 3'b101, 16'h8001, 16'h0000, 4'd1,  16'h4000};
      vecs[6]  = '{1'b0, 3'b110, 16'h8001, 16'h0000, 4'd1,  16'hC000};
      vecs[7]  = '{1'b1, 3'b111, 16'h8001, 16'h0000, 4'd1,  16'h0003};
      vecs[8]  = '{1'b0, 3'b111, 16'h8001, 16'h0000, 4'd0,  16'h8001};
      vecs[9]  = '{1'b1, 3'b111, 16'h1234, 16'h0000, 4'd4,  16'h2341};
      vecs[10] = '{1'b0, 3'b110, 16'h7000, 16'h0000, 4'd15, 16'h0000};
      vecs[11] = '{1'b1, 3'b110, 16'h8000, 16'h0000, 4'd15, 16'hFFFF};
      vecs[12] = '{1'b0, 3'b000, 16'hFFFF, 16'h0001, 4'd0,  16'h0000};
      vecs[13] = '{1'b0, 3'b001, 16'h0005, 16'h0005, 4'd0,  16'h0000};
      vecs[14] = '{1'b1, 3'b001, 16'h0000, 16'h0001, 4'd0,  16'hFFFF};

      rst_n     = 1'b0;
      rsp_ready = 1'b0;
      drive(0, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
      drive(1, 1'b0, 3'b000, 16'h0, 16'h0, 4'd0);
      #2;
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_data", rsp_data, 0);
      check("reset_rsp_id", rsp_id, 0);
      check("reset_op_count", op_count, 0);
      check("reset_ready", {req1_ready, req0_ready}, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Round robin: both requesters valid every cycle.
      rsp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         drive(0, 1'b1, 3'b000, 16'h0100 + 16'(i), 16'h0000, 4'd0);
         drive(1, 1'b1, 3'b000, 16'h0200 + 16'(i), 16'h0000, 4'd0);
         if (i % 2 == 0) sb.push_back('{16'h0100 + 16'(i), 1'b0});
         else            sb.push_back('{16'h0200 + 16'(i), 1'b1});
         @(negedge clk);
         check($sformatf("rr%0d_ready0", i), req0_ready, (i % 2 == 0));
         check($sformatf("rr%0d_ready1", i), req1_ready, (i % 2 == 1));
      end
      @(posedge clk); #1;
      idle();
      drain("rr_drain");

      // Vector table, one operation per cycle back to back.
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         idle();
         drive(int'(vecs[i].req), 1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm);
         sb.push_back('{vecs[i].exp, vecs[i].req});
         @(negedge clk);
         check($sformatf("vec%0d_ready", i), vecs[i].req ? req1_ready : req0_ready, 1);
      end
      @(posedge clk); #1;
      idle();
      drain("vec_drain");

      // Backpressure: held result must stay stable and block req1.
      @(posedge clk); #1;
      drive(0, 1'b1, 3'b000, 16'h1234, 16'h0000, 4'd0);
      sb.push_back('{16'h1234, 1'b0});
      @(negedge clk);
      check("bp_first_ready", req0_ready, 1);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         idle();
         rsp_ready = 1'b0;
         drive(1, 1'b1, 3'b011, 16'h00F0, 16'h000F, 4'd0);
         @(negedge clk);
         check($sformatf("bp%0d_req1_ready", i), req1_ready, 0);
         check($sformatf("bp%0d_rsp_valid", i), rsp_valid, 1);
         check($sformatf("bp%0d_rsp_data", i), rsp_data, 16'h1234);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      sb.push_back('{16'h00FF, 1'b1});
      @(negedge clk);
      check("bp_release_req1_ready", req1_ready, 1);
      @(posedge clk); #1;
      idle();
      drain("bp_drain");

      // Reset while FULL discards the held result.
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      drive(1, 1'b1, 3'b000, 16'h0055, 16'h0000, 4'd0);
      @(negedge clk);
      check("empty_accepts_without_rsp_ready", req1_ready, 1);
      @(posedge clk); #1;
      idle();
      check("full_before_reset", rsp_valid, 1);
      check("held_before_reset", rsp_data, 16'h0055);
      #2;
      rst_n = 1'b0;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      check("async_rst_rsp_valid", rsp_valid, 0);
      check("async_rst_op_count", op_count, 0);
      check("async_rst_rsp_data", rsp_data, 0);
      check("async_rst_ready", {req1_ready, req0_ready}, 0);
      sb.delete();
      exp_count = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      drive(0, 1'b1, 3'b001, 16'h0010, 16'h0001, 4'd0);
      drive(1, 1'b1, 3'b000, 16'h0300, 16'h0000, 4'd0);
      sb.push_back('{16'h000F, 1'b0});
      @(negedge clk);
      check("post_reset_tie_ready0", req0_ready, 1);
      check("post_reset_tie_ready1", req1_ready, 0);
      @(posedge clk); #1;
      idle();
      drain("post_reset_drain");

      // rsp_ready while EMPTY must not count.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("empty_rsp_ready_no_count", op_count, exp_count);
      check("empty_rsp_valid", rsp_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, width of the completed-operation counter.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid / req1_valid  input  1  requester 0/1 presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester 0/1 operation accepted this cycle.
REQ-006 req0_op / req1_op  input  3  ALU opcode.
REQ-007 req0_a, req0_b / req1_a, req1_b  input  16  signed operands.
REQ-008 req0_imm / req1_imm  input  4  shift/rotate amount.
REQ-009 rsp_valid  output  1  result register holds a result.
REQ-010 rsp_ready  input  1  consumer takes the result.
REQ-011 rsp_data  output  16  registered result.
REQ-012 rsp_id  output  1  requester index that produced rsp_data.
REQ-013 op_count  output  CNT_W  number of results consumed, wraps modulo 2^CNT_W.

Function
REQ-014 Opcodes SHALL compute: 000 A+B, 001 A-B, 010 A&B, 011 A|B, 100 A<<imm, 101 logical A>>imm, 110 arithmetic A>>>imm, 111 rotate-left A by imm; results truncated to 16 bits, no overflow detection.
REQ-015 Rotate with imm=0 SHALL return A unchanged.
REQ-016 The FSM SHALL have two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 A transfer SHALL occur for requester i when reqi_valid and reqi_ready are both 1.
REQ-018 Grant: one valid requester SHALL be granted alone; with both valid, the requester not granted last SHALL be granted (round robin).
REQ-019 The round-robin pointer SHALL update only on a completed transfer, not on a grant without transfer.
REQ-020 reqi_ready SHALL be 1 only when requester i is granted and (state EMPTY or rsp_ready=1); at most one ready high per cycle.
REQ-021 reqi_ready SHALL NOT depend on reqi_op, operands or imm; requesters SHALL NOT make valid depend on ready.
REQ-022 Latency SHALL be one cycle: operation transferred in cycle N appears on rsp_data/rsp_id with rsp_valid=1 in cycle N+1.
REQ-023 EMPTY + transfer -> FULL; FULL + rsp_ready + transfer -> FULL with new result (one op/cycle sustained); FULL + rsp_ready, no transfer -> EMPTY; FULL, rsp_ready=0 -> hold rsp_data/rsp_id stable.
REQ-024 op_count SHALL increment by 1 in each cycle where rsp_valid and rsp_ready are both 1, wrapping from all-ones to 0.
REQ-025 rsp_ready while EMPTY SHALL have no effect.

Reset
REQ-026 While rst_n=0: rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0, both ready=0, state EMPTY, pointer set so requester 0 wins the first tie.
REQ-027 Reset mid-operation SHALL discard any held result without a handshake; first transfer permitted on the first clk edge after rst_n rises.

Configuration
REQ-028 Macro ALU_ARBITER_FLAGS_EN defined: outputs rsp_zero (rsp_data==0) and rsp_neg (rsp_data[15]) SHALL exist, registered with rsp_data, reset to 0.
REQ-029 Macro undefined: rsp_zero and rsp_neg SHALL be absent; all other behaviour identical.

Structure
REQ-030 Opcode constants (OP_ADD..OP_ROL), DATA_W=16 and IMM_W=4 SHALL live in shared package alu_pkg.
REQ-031 The two-requester round-robin grant logic SHALL be sub-module rr_arb2 (inputs valid[1:0], advance; output grant[1:0]).

Verification
REQ-032 Req0 only: op=000, A=16'h7FFF, B=1, rsp_ready=1 -> next cycle rsp_data=16'h8000, rsp_id=0, op_count=1.
REQ-033 Both valid every cycle, rsp_ready=1, 6 cycles -> rsp_id sequence 0,1,0,1,0,1, one result per cycle.
REQ-034 rsp_ready=0 for 3 cycles with result 16'h1234 held, req1 valid -> req1_ready=0, rsp_data stable; rsp_ready=1 -> req1 accepted same cycle.
REQ-035 Shifts on A=16'h8001, imm=1: op 101 -> 16'h4000, op 110 -> 16'hC000, op 111 -> 16'h0003; op 111 imm=0 -> 16'h8001.
REQ-036 Assert rst_n=0 while FULL -> rsp_valid=0 immediately (asynchronous), op_count=0; after release tie grants requester 0.
REQ-037 With ALU_ARBITER_FLAGS_EN: op 001, A=5, B=5 -> rsp_zero=1, rsp_neg=0; A=0, B=1 -> rsp_data=16'hFFFF, rsp_neg=1.
